// File: rtl/hex_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_pkg
// Description : Shared definitions for the hex scan sequencer. Holds the
//               sequencer state enumeration and the default values of the
//               sequencer parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_scan_pkg;

    localparam int C_DEF_DATA_LEN   = 64;
    localparam int C_DEF_X_BITS     = 7;
    localparam int C_DEF_Y_BITS     = 7;
    localparam int C_DEF_WIDTH      = 128;
    localparam int C_DEF_HEIGHT     = 64;
    localparam int C_DEF_COLOR_BITS = 16;
    localparam int C_DEF_LATENCY    = 4;
    localparam int C_DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DRAIN = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/hex_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on rd_data whenever empty is low; rd_en pops it.
//               Writes to a full FIFO and reads from an empty one are ignored.
// Ports       : clk, reset (async, active-high)
//               wr_en / wr_data  - push side
//               rd_en / rd_data  - pop side (head visible without a read)
//               empty            - no entry stored
//               count            - number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0] c_cnt_full = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && (r_count != c_cnt_full);
    assign w_rd    = rd_en && (r_count != '0);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_sequencer
// Description : Walks a C_WIDTH x C_HEIGHT raster, issuing one coordinate per
//               clock to a pipelined decoder whose color returns C_LATENCY
//               clocks later. Colors land in an output FIFO and stream out
//               over a valid/ready pixel interface. Issue is credit-limited so
//               the FIFO can never overflow.
// Ports       : clk, reset (async, active-high)
//               start                      - frame request (IDLE only)
//               data_in                    - live hex data word
//               dec_x, dec_y, dec_data     - decoder request
//               dec_color                  - decoder response
//               pix_data/valid/ready/last  - pixel stream
//               busy, frame_done           - status
// Config      : HEX_SCAN_SNAPSHOT_EN - when defined, data_in is captured in
//               SNAP and held on dec_data for the whole frame; otherwise
//               dec_data follows data_in combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_sequencer
    import hex_scan_pkg::*;
#(
    parameter int C_DATA_LEN   = C_DEF_DATA_LEN,
    parameter int C_X_BITS     = C_DEF_X_BITS,
    parameter int C_Y_BITS     = C_DEF_Y_BITS,
    parameter int C_WIDTH      = C_DEF_WIDTH,
    parameter int C_HEIGHT     = C_DEF_HEIGHT,
    parameter int C_COLOR_BITS = C_DEF_COLOR_BITS,
    parameter int C_LATENCY    = C_DEF_LATENCY,
    parameter int C_FIFO_DEPTH = C_DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [C_DATA_LEN-1:0]   data_in,
    output logic [C_X_BITS-1:0]     dec_x,
    output logic [C_Y_BITS-1:0]     dec_y,
    output logic [C_DATA_LEN-1:0]   dec_data,
    input  logic [C_COLOR_BITS-1:0] dec_color,
    output logic [C_COLOR_BITS-1:0] pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_last,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int c_cw = $clog2(C_FIFO_DEPTH + 1);
    localparam int c_pw = C_X_BITS + C_Y_BITS + 1;
    localparam logic [C_X_BITS-1:0] c_x_last  = C_X_BITS'(C_WIDTH - 1);
    localparam logic [C_Y_BITS-1:0] c_y_last  = C_Y_BITS'(C_HEIGHT - 1);
    localparam logic [c_pw-1:0]     c_pix_end = c_pw'(C_WIDTH * C_HEIGHT - 1);
    localparam logic [c_cw:0]       c_depth   = (c_cw + 1)'(C_FIFO_DEPTH);
    localparam logic [C_X_BITS-1:0] c_x_one   = C_X_BITS'(1);
    localparam logic [C_Y_BITS-1:0] c_y_one   = C_Y_BITS'(1);
    localparam logic [c_pw-1:0]     c_pix_one = c_pw'(1);
    localparam logic [c_cw-1:0]     c_inf_one = c_cw'(1);

    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [C_X_BITS-1:0]       r_x;
    logic [C_Y_BITS-1:0]       r_y;
    logic [C_X_BITS-1:0]       r_hold_x;
    logic [C_Y_BITS-1:0]       r_hold_y;
    logic [c_cw-1:0]           r_inflight;
    logic [c_cw-1:0]           w_fifo_count;
    logic [c_cw:0]             w_used;
    logic [c_pw-1:0]           r_pix_cnt;
    logic                      r_frame_done;
    logic                      w_has_credit;
    logic                      w_issue;
    logic                      w_tag_exit;
    logic                      w_coord_last;
    logic                      w_accept;
    logic                      w_fifo_empty;
    logic [C_COLOR_BITS-1:0]   w_fifo_rd;

    // ------------------------------------------------------------------
    // Credit: every issued coordinate owns a FIFO slot from issue until
    // its pixel is popped, so issue stops once stored + inflight = depth.
    // ------------------------------------------------------------------
    assign w_used       = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_has_credit = (w_used < c_depth);
    assign w_issue      = (r_state == ST_SCAN) && w_has_credit;
    assign w_coord_last = (r_x == c_x_last) && (r_y == c_y_last);

    // The coordinate is presented in the issue clock itself so that a
    // zero-latency decoder can answer in the same clock; between issues
    // the last issued coordinate is held.
    assign dec_x = w_issue ? r_x : r_hold_x;
    assign dec_y = w_issue ? r_y : r_hold_y;

    assign pix_valid  = !w_fifo_empty;
    assign pix_data   = pix_valid ? w_fifo_rd : '0;
    assign pix_last   = pix_valid && (r_pix_cnt == c_pix_end);
    assign w_accept   = pix_valid && pix_ready;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SNAP;
            ST_SNAP:  w_state_nxt = ST_SCAN;
            ST_SCAN:  if (w_issue && w_coord_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_accept && pix_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Raster counters, held coordinate, output pixel counter, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_hold_x     <= '0;
            r_hold_y     <= '0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == ST_SNAP) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_issue) begin
                r_hold_x <= r_x;
                r_hold_y <= r_y;
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    r_y <= (r_y == c_y_last) ? '0 : r_y + c_y_one;
                end else begin
                    r_x <= r_x + c_x_one;
                end
            end

            if (r_state == ST_SNAP) begin
                r_pix_cnt <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + c_pix_one;
            end

            r_frame_done <= (r_state == ST_DRAIN) && w_accept && pix_last;
        end
    end

    // ------------------------------------------------------------------
    // Issue tag pipeline: aligns FIFO writes with the decoder latency.
    // ------------------------------------------------------------------
    generate
        if (C_LATENCY == 0) begin : g_tag_bypass
            assign w_tag_exit = w_issue;
        end else begin : g_tag_pipe
            logic [C_LATENCY-1:0] r_tag;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_tag <= '0;
                end else begin
                    r_tag[0] <= w_issue;
                    for (int i = 1; i < C_LATENCY; i++) begin
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end
            assign w_tag_exit = r_tag[C_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_tag_exit})
                2'b10:   r_inflight <= r_inflight + c_inf_one;
                2'b01:   r_inflight <= r_inflight - c_inf_one;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    hex_scan_fifo #(
        .WIDTH (C_COLOR_BITS),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_tag_exit),
        .wr_data (dec_color),
        .rd_en   (w_accept),
        .rd_data (w_fifo_rd),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Data word to the decoder
    // ------------------------------------------------------------------
`ifdef HEX_SCAN_SNAPSHOT_EN
    logic [C_DATA_LEN-1:0] r_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (r_state == ST_SNAP) begin
            r_data <= data_in;
        end
    end
    assign dec_data = r_data;
`else
    assign dec_data = data_in;
`endif

endmodule
`default_nettype wire
